// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel engine: two line buffers, shift window, one output register.
// Optional SOBEL_STREAM_CORE_STATS_EN adds output/saturation counters.
module sobel_stream_core #(
  parameter int WIDTH_P      = 8,
  parameter int MAX_LINE_W_P = 640,
  parameter int COL_W_P      = $clog2(MAX_LINE_W_P+1)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [COL_W_P-1:0] line_w_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  input  logic               sof_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
`ifdef SOBEL_STREAM_CORE_STATS_EN
  output logic               last_o,
  output logic [31:0]        out_cnt_o,
  output logic [31:0]        sat_cnt_o
`else
  output logic               last_o
`endif
);

  localparam int AW = (MAX_LINE_W_P > 1) ? $clog2(MAX_LINE_W_P) : 1;
  localparam int SW = WIDTH_P + 3;
  localparam int AB = WIDTH_P + 2;
  localparam int SM = WIDTH_P + 4;
  localparam logic [COL_W_P-1:0] MAXW = COL_W_P'(MAX_LINE_W_P);
  localparam logic [COL_W_P-1:0] MINW = COL_W_P'(3);
  localparam logic [COL_W_P-1:0] ONE  = COL_W_P'(1);
  localparam logic [COL_W_P-1:0] TWO  = COL_W_P'(2);

  logic [COL_W_P-1:0] col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [COL_W_P-1:0] line_w_q, line_w_d;
  logic               valid_q;
  logic [WIDTH_P-1:0] data_q;
  logic               last_q;

  logic               accept;
  logic [COL_W_P-1:0] col_eff;
  logic [1:0]         row_eff;
  logic [COL_W_P-1:0] lw_eff;
  logic [COL_W_P-1:0] lw_clamp;
  logic               wrap;
  logic               emit;
  logic [AW-1:0]      addr;

  assign ready_o = ready_i || !valid_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign accept  = valid_i && ready_o;

  always_comb begin
    lw_clamp = line_w_i;
    if (line_w_i < MINW) lw_clamp = MINW;
    else if (line_w_i > MAXW) lw_clamp = MAXW;
  end

  // An SOF pixel is treated as (row 0, col 0) of a frame of the new width.
  assign col_eff = sof_i ? '0 : col_q;
  assign row_eff = sof_i ? 2'd0 : row_q;
  assign lw_eff  = sof_i ? lw_clamp : line_w_q;
  assign wrap    = (col_eff == lw_eff - ONE);
  assign emit    = accept && (row_eff == 2'd2) && (col_eff >= TWO);
  assign addr    = col_eff[AW-1:0];

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    line_w_d = line_w_q;
    if (accept) begin
      line_w_d = lw_eff;
      col_d    = wrap ? '0 : col_eff + ONE;
      row_d    = row_eff;
      if (wrap && row_eff != 2'd2) row_d = row_eff + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q    <= '0;
      row_q    <= 2'd0;
      line_w_q <= MAXW;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      line_w_q <= line_w_d;
    end
  end

  logic [WIDTH_P-1:0] lb_top_q [MAX_LINE_W_P];
  logic [WIDTH_P-1:0] lb_mid_q [MAX_LINE_W_P];
  logic [WIDTH_P-1:0] top_rd, mid_rd;

  assign top_rd = lb_top_q[addr];
  assign mid_rd = lb_mid_q[addr];

  // Read-before-write: the mid row migrates up as the new pixel lands.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb_top_q[addr] <= mid_rd;
      lb_mid_q[addr] <= data_i;
    end
  end

  logic [WIDTH_P-1:0] wa_q [3];
  logic [WIDTH_P-1:0] wb_q [3];
  logic [WIDTH_P-1:0] nc [3];

  assign nc[0] = top_rd;
  assign nc[1] = mid_rd;
  assign nc[2] = data_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < 3; r++) begin
        wa_q[r] <= '0;
        wb_q[r] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        wa_q[r] <= wb_q[r];
        wb_q[r] <= nc[r];
      end
    end
  end

  logic [WIDTH_P-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
  assign p00 = wa_q[0];
  assign p01 = wb_q[0];
  assign p02 = nc[0];
  assign p10 = wa_q[1];
  assign p12 = nc[1];
  assign p20 = wa_q[2];
  assign p21 = wb_q[2];
  assign p22 = nc[2];

  logic [AB-1:0]        gxp, gxn, gyp, gyn;
  logic signed [SW-1:0] gx, gy, ngx, ngy;
  logic [AB-1:0]        agx, agy;
  logic [SM-1:0]        sum, pre;
  logic                 over;
  logic [WIDTH_P-1:0]   res;

  assign gxp = {2'b0, p02} + {1'b0, p12, 1'b0} + {2'b0, p22};
  assign gxn = {2'b0, p00} + {1'b0, p10, 1'b0} + {2'b0, p20};
  assign gyp = {2'b0, p20} + {1'b0, p21, 1'b0} + {2'b0, p22};
  assign gyn = {2'b0, p00} + {1'b0, p01, 1'b0} + {2'b0, p02};
  assign gx  = $signed({1'b0, gxp}) - $signed({1'b0, gxn});
  assign gy  = $signed({1'b0, gyp}) - $signed({1'b0, gyn});
  assign ngx = -gx;
  assign ngy = -gy;
  assign agx = gx[SW-1] ? ngx[AB-1:0] : gx[AB-1:0];
  assign agy = gy[SW-1] ? ngy[AB-1:0] : gy[AB-1:0];
  assign sum = {2'b0, agx} + {2'b0, agy};

  always_comb begin
    pre  = sum;
    over = 1'b0;
    res  = '0;
    unique case (1'b1)
      (mode_i == 2'd1): pre = {2'b0, agx};
      (mode_i == 2'd2): pre = {2'b0, agy};
      default:          pre = sum;
    endcase
    over = |pre[SM-1:WIDTH_P];
    if (mode_i == 2'd3)
      res = (sum >= {4'b0, thresh_i}) ? '1 : '0;
    else
      res = over ? '1 : pre[WIDTH_P-1:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      data_q  <= res;
      last_q  <= wrap;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef SOBEL_STREAM_CORE_STATS_EN
  logic        sat_q;
  logic [31:0] out_cnt_q, sat_cnt_q;
  logic        out_hs;

  assign out_hs    = valid_q && ready_i;
  assign out_cnt_o = out_cnt_q;
  assign sat_cnt_o = sat_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_q     <= 1'b0;
      out_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (emit) sat_q <= over && (mode_i != 2'd3);
      if (accept && sof_i) out_cnt_q <= '0;
      else if (out_hs && out_cnt_q != '1) out_cnt_q <= out_cnt_q + 32'd1;
      if (out_hs && sat_q && sat_cnt_q != '1) sat_cnt_q <= sat_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core: vector table plus SOF/reset sequences.
// Define SOBEL_STREAM_CORE_STATS_EN to also check the counters.
module tb_sobel_stream_core;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] line_w_i;
  logic [1:0] mode_i;
  logic [7:0] thresh_i;
  logic       sof_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       last_o;
`ifdef SOBEL_STREAM_CORE_STATS_EN
  logic [31:0] out_cnt, sat_cnt;
`endif

  always #5 clk = ~clk;

  sobel_stream_core dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .line_w_i (line_w_i),
    .mode_i   (mode_i),
    .thresh_i (thresh_i),
    .sof_i    (sof_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
`ifdef SOBEL_STREAM_CORE_STATS_EN
    .last_o   (last_o),
    .out_cnt_o(out_cnt),
    .sat_cnt_o(sat_cnt)
`else
    .last_o   (last_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } out_t;
  out_t q[$];

  typedef struct packed {
    int              lw;
    int              rows;
    int              pat;
    logic [1:0]      mode;
    logic [7:0]      th;
    logic            stall;
    int              n;
    int              per;
    logic [0:7][7:0] e;
  } vec_t;
  vec_t v[11];

  logic stall_en = 1'b0;
  logic ready_lvl = 1'b1;

  always @(posedge clk) begin
    #2;
    ready_i = stall_en ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && valid_o) begin
        checks++;
        if (data_o !== hold_d || last_o !== hold_l) begin
          failures++;
          $display("FAIL stall_hold: got d=%0d l=%0b expected d=%0d l=%0b",
                   data_o, last_o, hold_d, hold_l);
        end
      end
      if (valid_o && ready_i) q.push_back({data_o, last_o});
      hold_v = valid_o && !ready_i;
      hold_d = data_o;
      hold_l = last_o;
    end
  end

  function automatic logic [7:0] pix(input int pat, input int r,
                                     input int c, input int w);
    case (pat)
      0:       return 8'd100;
      1:       return (c >= w / 2) ? 8'd255 : 8'd0;
      2:       return 8'(c * 10);
      default: return 8'(r * 10 + c * 10);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic s,
                         input logic [9:0] lw);
    int n;
    n = 0;
    if (stall_en && $urandom_range(0, 1) == 1) begin
      valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    valid_i  = 1'b1;
    data_i   = d;
    sof_i    = s;
    line_w_i = lw;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL input_timeout: got ready_o=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic drive_frame(input int lw_in, input int w, input int rows,
                             input int pat, input int npix);
    int tot;
    tot = w * rows;
    if (npix >= 0 && npix < tot) tot = npix;
    q.delete();
    for (int k = 0; k < tot; k++)
      send_px(pix(pat, k / w, k % w, w), k == 0, 10'(lw_in));
    stall_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input int n, input int per,
                           input logic [0:7][7:0] e);
    chk({nm, "_count"}, q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      chk($sformatf("%s_data%0d", nm, i), int'(q[i].d), int'(e[i % per]));
      chk($sformatf("%s_last%0d", nm, i), int'(q[i].l),
          (i % per == per - 1) ? 1 : 0);
    end
  endtask

  task automatic run_vec(input int i);
    mode_i   = v[i].mode;
    thresh_i = v[i].th;
    stall_en = v[i].stall;
    drive_frame(v[i].lw, v[i].lw, v[i].rows, v[i].pat, -1);
    check_out($sformatf("vec%0d", i), v[i].n, v[i].per, v[i].e);
  endtask

  initial begin
    int k, cyc;
    logic acc;
    v[0]  = '{8, 5, 0, 2'd0, 8'd0, 1'b0, 18, 6, '{8{8'd0}}};
    v[1]  = '{8, 4, 1, 2'd0, 8'd0, 1'b0, 12, 6,
              '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}};
    v[2]  = '{8, 4, 1, 2'd2, 8'd0, 1'b0, 12, 6, '{8{8'd0}}};
    v[3]  = '{10, 3, 2, 2'd1, 8'd0, 1'b0, 8, 8, '{8{8'd80}}};
    v[4]  = '{10, 3, 2, 2'd3, 8'd81, 1'b0, 8, 8, '{8{8'd0}}};
    v[5]  = '{10, 3, 2, 2'd3, 8'd80, 1'b0, 8, 8, '{8{8'd255}}};
    v[6]  = '{10, 4, 3, 2'd0, 8'd0, 1'b0, 16, 8, '{8{8'd160}}};
    v[7]  = '{10, 4, 3, 2'd2, 8'd0, 1'b0, 16, 8, '{8{8'd80}}};
    v[8]  = '{10, 4, 3, 2'd3, 8'd161, 1'b0, 16, 8, '{8{8'd0}}};
    v[9]  = '{8, 4, 1, 2'd0, 8'd0, 1'b1, 12, 6,
              '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}};
    v[10] = '{8, 4, 1, 2'd1, 8'd0, 1'b1, 12, 6,
              '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}};

    rstn = 1'b0;
    line_w_i = '0;
    mode_i = '0;
    thresh_i = '0;
    sof_i = 1'b0;
    valid_i = 1'b0;
    data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_last", int'(last_o), 0);
    chk("rst_ready", int'(ready_o), 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_vec(i);
`ifdef SOBEL_STREAM_CORE_STATS_EN
      if (i == 0) chk("stats_out_cnt", int'(out_cnt), 18);
      if (i == 1) chk("stats_sat_pos", int'(sat_cnt > 0), 1);
`endif
    end

    // Abandoned frame then narrower frame: old rows must not leak.
    mode_i = 2'd0;
    drive_frame(8, 8, 3, 1, 20);
    check_out("partial", 2, 6, '{8{8'd0}});
    drive_frame(4, 4, 4, 1, -1);
    check_out("sof_w4", 4, 2, '{8{8'd255}});
    mode_i = 2'd1;
    drive_frame(1, 3, 4, 2, -1);
    check_out("sof_w1", 2, 1, '{8{8'd80}});

    // Reset while an output is held by back-pressure.
    ready_lvl = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    cyc = 0;
    while (!valid_o && cyc < 60) begin
      valid_i = 1'b1;
      data_i  = pix(2, k / 8, k % 8, 8);
      sof_i   = (k == 0);
      line_w_i = 10'd8;
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    valid_i = 1'b0;
    sof_i = 1'b0;
    chk("rst_setup_valid", int'(valid_o), 1);
    chk("rst_setup_data", int'(data_o), 80);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid_o), 0);
    chk("async_rst_data", int'(data_o), 0);
    #3;
    rstn = 1'b1;
    ready_lvl = 1'b1;
    @(posedge clk);
    #1;
    run_vec(0);
`ifdef SOBEL_STREAM_CORE_STATS_EN
    chk("stats_out_cnt_post_rst", int'(out_cnt), 18);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_stream_core.md
Name: sobel_stream_core

Overview:
- Self-contained streaming 3x3 Sobel engine, the parametrised successor to the fixed-function gray-to-edge chain in the UART image pipeline.
- Accepts one grayscale pixel per handshake at a run-time line width up to MAX_LINE_W_P. Emits one edge pixel per interior window.
- Selectable output mode: saturated |gx|+|gy|, |gx| only, |gy| only, or thresholded binary.
- Sits between rgb2gray and the output packer.

Parameters:
- WIDTH_P, 8, pixel bit width, in and out.
- MAX_LINE_W_P, 640, maximum line width; sets line-buffer depth.
- COL_W_P, $clog2(MAX_LINE_W_P+1), column counter and line_w_i width. Derived; do not override.

Ports:
- clk_i  in  1  core clock.
- rstn_i  in  1  reset, asynchronous assert, active-low.
- line_w_i  in  COL_W_P  line width, sampled on SOF handshake.
- mode_i  in  2  0=sum, 1=|gx|, 2=|gy|, 3=binary. Sampled per output.
- thresh_i  in  WIDTH_P  binary-mode threshold.
- sof_i  in  1  start of frame, qualified by valid_i.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  input ready.
- data_i  in  WIDTH_P  grayscale pixel.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.
- data_o  out  WIDTH_P  edge pixel.
- last_o  out  1  last output pixel of a row.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values: valid_o=0, data_o=0, last_o=0, col=0, row=0, line_w_q=MAX_LINE_W_P, window registers 0. Line-buffer RAM is not reset.
- Handshake: transfer occurs when valid_i && ready_o. ready_o = ready_i || !valid_o (single output register). data_o and last_o are held stable while valid_o && !ready_i.
- SOF: an accepted pixel with sof_i=1 is (row 0, col 0).
  - line_w_q is loaded with line_w_i, clamped to the range 3..MAX_LINE_W_P.
  - A mid-frame SOF abandons the current frame. A pending output already in the output register is still delivered.
- Counters: col increments per accepted pixel and wraps to 0 after line_w_q-1. On wrap, row increments, saturating at 2.
- Line buffers: two rows, each MAX_LINE_W_P x WIDTH_P, addressed by col. Reading and writing the same address in the same cycle returns the old data.
- Window: a 3x3 shift window is fed by the two line-buffer reads plus data_i. Column 2 is the newest pixel; row 2 is the current row.
- Arithmetic:
  - gx = (p02+2p12+p22)-(p00+2p10+p20), signed WIDTH_P+3 bits.
  - gy = (p20+2p21+p22)-(p00+2p01+p02), signed WIDTH_P+3 bits.
  - Absolute values are taken, then the sum is formed in WIDTH_P+4 bits.
- Mode selection:
  - Modes 0, 1 and 2 saturate their result to 2^WIDTH_P-1.
  - Mode 3 outputs all-ones if |gx|+|gy| >= thresh_i, else 0.
- Output rule: an output is produced for an accepted pixel iff row==2 (saturated) && col>=2.
  - Latency: valid_o rises the cycle after the completing handshake.
  - last_o=1 when that pixel's col==line_w_q-1.
- Output count: a frame of W x H produces (W-2) x (H-2) outputs. No border outputs and no flushing.
- Asynchronous reset mid-operation drops valid_o immediately. Any partial frame is discarded.

Optional Feature:
- Macro SOBEL_STREAM_CORE_STATS_EN.
- When defined, adds two outputs:
  - out_cnt_o [31:0]: counts output handshakes; clears on reset and on SOF handshake.
  - sat_cnt_o [31:0]: counts outputs in modes 0, 1 and 2 whose pre-saturation value exceeded 2^WIDTH_P-1.
  - Both counters hold at all-ones rather than wrapping.
- When undefined, neither port nor logic exists; behaviour is otherwise identical.

Test Plan:
1. line_w=8, 5 rows, all pixels 100, mode 0 -> 18 outputs, all 0; last_o on every 6th output.
2. line_w=8, cols 0-3=0 and cols 4-7=255, 4 rows, mode 0 -> each output row is 0,0,255,255,0,0. Same input in mode 2 -> all outputs 0.
3. Ramp pixel=col*10, line_w=10, mode 1 -> every output 80.
   - Mode 3 with thresh_i=81 -> all outputs 0.
   - Mode 3 with thresh_i=80 -> all outputs 255.
4. Test 2 stimulus with ready_i toggled pseudo-randomly at 50% and bursty valid_i -> output sequence identical to the no-stall run; data_o/last_o stable during stalls; no loss or duplication.
5. line_w=8, send 20 pixels, then SOF with line_w=4 -> no output until the new frame's row 2 col 2. Then 2 outputs per row with last_o on each second output.
   - line_w_i=1 on SOF -> behaves as width 3.
6. Deassert rstn_i mid-frame while valid_o=1 -> valid_o=0 immediately. After release, a fresh frame produces the correct count and values. STATS build: out_cnt_o=18 after test 1; sat_cnt_o>0 after test 2.
